// File: rtl/rx_ingress_stamper.sv
// -----------------------------------------------------------------------------
// rx_ingress_stamper
//
// Per-port ingress stage that sits between an RX queue and a datapath slave
// stream port. On the first beat of each packet it writes the PTP ingress
// time and the source-port one-hot into tuser. It counts the bytes of each
// packet. A frame that grows beyond MAX_FRAME_BYTES is cut short: tlast is
// forced on the offending beat, tuser[64] flags the truncation, and the rest
// of the frame is swallowed.
//
// Pipeline: an output register plus one skid register. s_axis_tready is
// registered and means "skid register empty", so the stage sustains one beat
// per cycle while m_axis_tready stays high.
//
// Optional build macro: RX_STAMPER_STATS_EN
//   defined   -> stat_pkt_count / stat_trunc_count are live counters
//   undefined -> both counters are tied to 0 and stat_clear is ignored
//
// Ports:
//   axis_aclk, axis_resetn      clock, asynchronous active-low reset
//   sync_time_ptp_ns[31:0]      PTP nanoseconds sampled on the SOP accept
//   s_axis_*                    input stream (tdata/tkeep/tuser/tvalid/tlast, tready out)
//   m_axis_*                    output stream (tdata/tkeep/tuser/tvalid/tlast, tready in)
//   stat_clear                  synchronous clear of both counters
//   stat_pkt_count[31:0]        packets emitted (m-side beats with tlast)
//   stat_trunc_count[31:0]      packets truncated
// -----------------------------------------------------------------------------
module rx_ingress_stamper #(
  parameter int         AXIS_DATA_WIDTH  = 256,
  parameter int         AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] SRC_PORT_ONEHOT  = 8'h01,
  parameter int         MAX_FRAME_BYTES  = 1522,
  parameter int         TS_LSB           = 32
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [31:0]                   sync_time_ptp_ns,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic                          stat_clear,
  output logic [31:0]                   stat_pkt_count,
  output logic [31:0]                   stat_trunc_count
);

  localparam int          KEEP_W    = AXIS_DATA_WIDTH / 8;
  localparam logic [16:0] MAX_BYTES = 17'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PKT  = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  function automatic logic [15:0] popcount(input logic [KEEP_W-1:0] keep);
    logic [15:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + {15'd0, keep[i]};
    end
    return cnt;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t                        r_state;
  logic [15:0]                   r_byte_cnt;
  logic                          r_s_tready;

  logic [AXIS_DATA_WIDTH-1:0]    r_out_data;
  logic [KEEP_W-1:0]             r_out_keep;
  logic [AXIS_TUSER_WIDTH-1:0]   r_out_user;
  logic                          r_out_last;
  logic                          r_out_vld;

  logic [AXIS_DATA_WIDTH-1:0]    r_skid_data;
  logic [KEEP_W-1:0]             r_skid_keep;
  logic [AXIS_TUSER_WIDTH-1:0]   r_skid_user;
  logic                          r_skid_last;
  logic                          r_skid_vld;

  logic                          w_accept;
  logic                          w_sop;
  logic                          w_fwd;
  logic                          w_push;
  logic [15:0]                   w_cnt_next;
  logic                          w_trunc;
  logic [AXIS_TUSER_WIDTH-1:0]   w_beat_user;
  logic                          w_beat_last;
  logic                          w_out_ready;
  logic                          w_skid_vld_next;

  assign w_accept = s_axis_tvalid & r_s_tready;
  assign w_sop    = (r_state == ST_IDLE);
  assign w_fwd    = (r_state != ST_DISCARD);
  assign w_push   = w_accept & w_fwd;

  // Byte count restarts at SOP; saturation keeps a runaway frame from wrapping
  // back under the limit.
  assign w_cnt_next = sat_add16(w_sop ? 16'd0 : r_byte_cnt, popcount(s_axis_tkeep));

  // A frame that exceeds the limit exactly on its last beat is let through.
  assign w_trunc = w_fwd & ({1'b0, w_cnt_next} > MAX_BYTES) & ~s_axis_tlast;

  always_comb begin
    w_beat_user = s_axis_tuser;
    if (w_sop) begin
      w_beat_user[TS_LSB +: 32] = sync_time_ptp_ns;
      w_beat_user[23:16]        = SRC_PORT_ONEHOT;
      w_beat_user[64]           = 1'b0;
    end
    if (w_trunc) begin
      w_beat_user[64] = 1'b1;
    end
    w_beat_last = s_axis_tlast | w_trunc;
  end

  // ---- packet state machine (updates on every accepted beat) ----
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE, ST_IN_PKT: begin
          r_byte_cnt <= w_cnt_next;
          if (w_trunc)           r_state <= ST_DISCARD;
          else if (s_axis_tlast) r_state <= ST_IDLE;
          else                   r_state <= ST_IN_PKT;
        end
        ST_DISCARD: begin
          if (s_axis_tlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---- output register + skid register ----
  // The output register may load whenever it is empty or being drained. A
  // beat that arrives while the output is stalled parks in the skid register,
  // which also drops s_axis_tready for the next cycle.
  assign w_out_ready     = ~r_out_vld | m_axis_tready;
  assign w_skid_vld_next = w_out_ready ? 1'b0 : (r_skid_vld | w_push);

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_user  <= '0;
      r_out_last  <= 1'b0;
      r_out_vld   <= 1'b0;
      r_skid_data <= '0;
      r_skid_keep <= '0;
      r_skid_user <= '0;
      r_skid_last <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_s_tready  <= 1'b0;
    end else begin
      if (w_out_ready) begin
        if (r_skid_vld) begin
          r_out_data <= r_skid_data;
          r_out_keep <= r_skid_keep;
          r_out_user <= r_skid_user;
          r_out_last <= r_skid_last;
          r_out_vld  <= 1'b1;
        end else if (w_push) begin
          r_out_data <= s_axis_tdata;
          r_out_keep <= s_axis_tkeep;
          r_out_user <= w_beat_user;
          r_out_last <= w_beat_last;
          r_out_vld  <= 1'b1;
        end else begin
          r_out_vld  <= 1'b0;
        end
      end else if (w_push) begin
        r_skid_data <= s_axis_tdata;
        r_skid_keep <= s_axis_tkeep;
        r_skid_user <= w_beat_user;
        r_skid_last <= w_beat_last;
      end
      r_skid_vld <= w_skid_vld_next;
      r_s_tready <= ~w_skid_vld_next;
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tkeep  = r_out_keep;
  assign m_axis_tuser  = r_out_user;
  assign m_axis_tlast  = r_out_last;
  assign m_axis_tvalid = r_out_vld;

  // ---- statistics ----
`ifdef RX_STAMPER_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_trunc_count;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_pkt_count   <= '0;
      r_trunc_count <= '0;
    end else if (stat_clear) begin
      r_pkt_count   <= '0;
      r_trunc_count <= '0;
    end else begin
      if (r_out_vld & m_axis_tready & r_out_last) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_accept & w_trunc)                     r_trunc_count <= r_trunc_count + 32'd1;
    end
  end

  assign stat_pkt_count   = r_pkt_count;
  assign stat_trunc_count = r_trunc_count;
`else
  logic w_unused_stat_clear;
  assign w_unused_stat_clear = stat_clear;
  assign stat_pkt_count      = '0;
  assign stat_trunc_count    = '0;
`endif

endmodule

// File: tb/tb_rx_ingress_stamper.sv
// -----------------------------------------------------------------------------
// tb_rx_ingress_stamper
//
// Directed bench for rx_ingress_stamper with default parameters. A packet-level
// reference model builds the expected output stream from every accepted input
// beat; one compare process checks outputs and counters each cycle. Directed
// tests then pin key values with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_rx_ingress_stamper;

  localparam int DW   = 256;
  localparam int KW   = 32;
  localparam int UW   = 128;
  localparam int MAXB = 1522;
`ifdef RX_STAMPER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          axis_resetn;
  logic [31:0]   sync_time_ptp_ns;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          stat_clear;
  logic [31:0]   stat_pkt_count;
  logic [31:0]   stat_trunc_count;

  rx_ingress_stamper dut (
    .axis_aclk        (clk),
    .axis_resetn      (axis_resetn),
    .sync_time_ptp_ns (sync_time_ptp_ns),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tuser     (s_axis_tuser),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tkeep     (m_axis_tkeep),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .stat_clear       (stat_clear),
    .stat_pkt_count   (stat_pkt_count),
    .stat_trunc_count (stat_trunc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  int n_chk  = 0;
  int n_fail = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] log_data[$];
  logic [UW-1:0] log_user[$];
  logic          log_last[$];
  int            log_cyc[$];

  bit m_in_pkt = 0;
  bit m_disc   = 0;
  int m_bytes  = 0;
  int m_pkt    = 0;
  int m_trunc  = 0;
  int cyc      = 0;

  bit tog_mode = 0;
  bit rdy_lvl  = 1;
  int max_run  = 0;

  bit          ts_load = 0;
  int unsigned ts_val  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event, required one", name);
  endtask

  function automatic logic [DW-1:0] mk_data(input int n);
    return {8{32'(n)}};
  endfunction

  // [15:0] length, [23:16] junk that SOP must overwrite, [31:24] dst port,
  // bit 64 set so the SOP clear and non-SOP passthrough are both visible.
  function automatic logic [UW-1:0] mk_user(input int n);
    return {32'(n), 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h4455_0040};
  endfunction

  // Reference model: packet-level rules applied to one accepted input beat.
  task automatic model_accept();
    beat_t e;
    bit    sop;
    if (m_disc) begin
      if (s_axis_tlast) m_disc = 0;
      return;
    end
    sop     = !m_in_pkt;
    m_bytes = (sop ? 0 : m_bytes) + $countones(s_axis_tkeep);
    if (m_bytes > 65535) m_bytes = 65535;
    e.d = s_axis_tdata;
    e.k = s_axis_tkeep;
    e.u = s_axis_tuser;
    e.l = s_axis_tlast;
    if (sop) begin
      e.u[63:32] = sync_time_ptp_ns;
      e.u[23:16] = 8'h01;
      e.u[64]    = 1'b0;
    end
    if (m_bytes > MAXB && !s_axis_tlast) begin
      e.l      = 1'b1;
      e.u[64]  = 1'b1;
      m_disc   = 1;
      m_in_pkt = 0;
      m_trunc++;
    end else begin
      m_in_pkt = !s_axis_tlast;
    end
    exp_q.push_back(e);
  endtask

  // Compare process: everything sampled on the falling edge.
  initial begin
    beat_t e;
    beat_t prev;
    bit    prev_hold;
    int    run;
    prev_hold = 0;
    run       = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!axis_resetn) begin
        exp_q.delete();
        m_in_pkt  = 0;
        m_disc    = 0;
        m_bytes   = 0;
        m_pkt     = 0;
        m_trunc   = 0;
        prev_hold = 0;
        run       = 0;
        continue;
      end
      chk("stat_pkt_count", stat_pkt_count, STATS ? 32'(m_pkt) : 32'd0);
      chk("stat_trunc_count", stat_trunc_count, STATS ? 32'(m_trunc) : 32'd0);
      if (prev_hold) begin
        chk("hold_data", m_axis_tdata, prev.d);
        chk("hold_ctl", {m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid},
            {prev.u, prev.k, prev.l, 1'b1});
      end
      prev_hold = m_axis_tvalid & !m_axis_tready;
      prev.d = m_axis_tdata;
      prev.k = m_axis_tkeep;
      prev.u = m_axis_tuser;
      prev.l = m_axis_tlast;
      if (tog_mode) begin
        run = s_axis_tready ? 0 : run + 1;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_axis_tdata, e.d);
          chk("out_keep", m_axis_tkeep, e.k);
          chk("out_user", m_axis_tuser, e.u);
          chk("out_last", m_axis_tlast, e.l);
        end
        log_data.push_back(m_axis_tdata);
        log_user.push_back(m_axis_tuser);
        log_last.push_back(m_axis_tlast);
        log_cyc.push_back(cyc);
        if (m_axis_tlast) m_pkt++;
      end
      if (s_axis_tvalid && s_axis_tready) model_accept();
      if (stat_clear) begin
        m_pkt   = 0;
        m_trunc = 0;
      end
    end
  end

  // PTP time source: advances 8 ns per cycle, wraps at one second,
  // optionally reloaded by the stimulus.
  initial begin
    sync_time_ptp_ns = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (ts_load) begin
        sync_time_ptp_ns = ts_val;
        ts_load          = 0;
      end else begin
        sync_time_ptp_ns = (sync_time_ptp_ns + 32'd8) % 32'd1_000_000_000;
      end
    end
  end

  // Sink ready: constant level or 1010 toggle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_mode) m_axis_tready = ~m_axis_tready;
      else          m_axis_tready = rdy_lvl;
    end
  end

  task automatic set_ts(input int unsigned v);
    ts_val  = v;
    ts_load = 1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic [UW-1:0] u, input logic l);
    bit ok;
    ok = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    if (!ok) fail_now("send_accept");
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0 && !m_axis_tvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_m_tkeep_tlast"}, {m_axis_tkeep, m_axis_tlast}, 0);
    chk({tag, "_m_tuser"}, m_axis_tuser, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_stats"}, {stat_pkt_count, stat_trunc_count}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  localparam logic [KW-1:0] ONES = '1;

  initial begin
    int            base;
    int            bad;
    logic [UW-1:0] u;
    logic [UW-1:0] u2;
    logic [31:0]   d0;
    logic [31:0]   d1;

    axis_resetn   = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    stat_clear    = 1'b0;

    // Reset state and ready rising on the first edge after release.
    #1;
    chk_outputs_zero("rst");
    repeat (3) @(posedge clk);
    #3;
    axis_resetn = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", s_axis_tready, 0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", s_axis_tready, 1);

    // 64-byte packet, stamp 1000.
    base = log_data.size();
    set_ts(1000);
    send(mk_data(1), ONES, mk_user(1), 1'b0);
    send(mk_data(2), ONES, mk_user(2), 1'b1);
    wait_drain();
    chk("t1_beats", 32'(log_data.size() - base), 2);
    u = log_user[base];
    chk("t1_ts", u[63:32], 1000);
    chk("t1_src", u[23:16], 8'h01);
    chk("t1_bit64", u[64], 0);
    chk("t1_len_dst", {u[31:24], u[15:0]}, 24'h44_0040);
    chk("t1_beat1_user", log_user[base+1], mk_user(2));
    chk("t1_lasts", {log_last[base], log_last[base+1]}, 2'b01);
    chk("t1_pkt_count", stat_pkt_count, STATS ? 32'd1 : 32'd0);

    // 100 back-to-back single-beat packets at full rate.
    base = log_data.size();
    for (int i = 0; i < 100; i++) send(mk_data(100 + i), ONES, mk_user(i), 1'b1);
    wait_drain();
    chk("t2_beats", 32'(log_data.size() - base), 100);
    chk("t2_span", 32'(log_cyc[base+99] - log_cyc[base]), 99);
    bad = 0;
    for (int i = 1; i < 100; i++) begin
      u  = log_user[base+i];
      u2 = log_user[base+i-1];
      d0 = u2[63:32];
      d1 = u[63:32];
      if (d1 - d0 != 32'd8) bad++;
    end
    chk("t2_ts_step8", 32'(bad), 0);

    // 4-beat packet under 1010 sink backpressure.
    base    = log_data.size();
    max_run = 0;
    tog_mode = 1;
    for (int i = 0; i < 4; i++) send(mk_data(200 + i), ONES, mk_user(20), i == 3);
    wait_drain();
    tog_mode = 0;
    chk("t3_beats", 32'(log_data.size() - base), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", log_data[base+i], mk_data(200 + i));
    chk("t3_tready_low_run_le1", max_run <= 1, 1);

    // 1600-byte frame truncated at beat 48, then a normal packet.
    base = log_data.size();
    for (int i = 0; i < 50; i++) send(mk_data(300 + i), ONES, mk_user(7), i == 49);
    set_ts(5000);
    send(mk_data(400), ONES, mk_user(8), 1'b1);
    wait_drain();
    chk("t4_beats", 32'(log_data.size() - base), 49);
    chk("t4_last47_48", {log_last[base+46], log_last[base+47]}, 2'b01);
    u = log_user[base+47];
    chk("t4_trunc_flag", u[64], 1);
    chk("t4_trunc_data", log_data[base+47], mk_data(347));
    chk("t4_trunc_count", stat_trunc_count, STATS ? 32'd1 : 32'd0);
    u = log_user[base+48];
    chk("t4_next_ts", u[63:32], 5000);
    chk("t4_next_flag_src", {u[64], u[23:16]}, 9'h001);
    chk("t4_next_data", log_data[base+48], mk_data(400));

    // Counter clear.
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    stat_clear = 1'b0;
    chk("clr_counts", {stat_pkt_count, stat_trunc_count}, 0);

    // Timestamp wrap: SOPs one cycle apart at 999_999_992.
    base = log_data.size();
    set_ts(999_999_992);
    send(mk_data(500), ONES, mk_user(5), 1'b1);
    send(mk_data(501), ONES, mk_user(6), 1'b1);
    wait_drain();
    u  = log_user[base];
    u2 = log_user[base+1];
    chk("t5_ts0", u[63:32], 999_999_992);
    chk("t5_ts1", u2[63:32], 0);

    // Reset pulse during beat 2 of a 4-beat packet.
    send(mk_data(600), ONES, mk_user(9), 1'b0);
    send(mk_data(601), ONES, mk_user(9), 1'b0);
    s_axis_tdata  = mk_data(602);
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    #2;
    axis_resetn = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    axis_resetn = 1'b1;
    @(posedge clk);
    #1;
    base = log_data.size();
    set_ts(7777);
    send(mk_data(603), ONES, mk_user(10), 1'b1);
    wait_drain();
    chk("t6_beats", 32'(log_data.size() - base), 1);
    u = log_user[base];
    chk("t6_ts", u[63:32], 7777);
    chk("t6_src", u[23:16], 8'h01);
    chk("t6_counts", {stat_pkt_count, stat_trunc_count}, STATS ? 64'h1_0000_0000 : 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_ingress_stamper.md
Name: rx_ingress_stamper

Overview:
- Per-port ingress stage between each RX queue and a `datapath_v3` slave stream port (`s_axis_N`); one instance per port.
- On the first beat of every packet:
  - stamps the PTP ingress time into tuser;
  - writes the source-port one-hot into tuser.
- Counts bytes per packet. Frames longer than MAX_FRAME_BYTES are truncated: tlast is forced and the remainder is discarded.
- Registered, full-throughput AXI-Stream pipeline with a skid buffer.

Parameters:
- AXIS_DATA_WIDTH, 256, tdata width in bits; tkeep width is AXIS_DATA_WIDTH/8.
- AXIS_TUSER_WIDTH, 128, tuser width; must be at least 65.
- SRC_PORT_ONEHOT, 8'h01, value written to tuser[23:16] on the first beat.
- MAX_FRAME_BYTES, 1522, maximum forwarded frame length in bytes.
- TS_LSB, 32, bit position of the 32-bit timestamp field in tuser.

Ports:
- axis_aclk  in  1  stream clock.
- axis_resetn  in  1  asynchronous active-low reset.
- sync_time_ptp_ns  in  32  PTP nanoseconds, range 0..999_999_999.
- s_axis_tdata  in  AXIS_DATA_WIDTH  input data.
- s_axis_tkeep  in  AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  AXIS_TUSER_WIDTH  sideband; [15:0] length, [31:24] dst port.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  AXIS_DATA_WIDTH  output data.
- m_axis_tkeep  out  AXIS_DATA_WIDTH/8  output byte enables.
- m_axis_tuser  out  AXIS_TUSER_WIDTH  output sideband.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- stat_clear  in  1  synchronous clear of both counters.
- stat_pkt_count  out  32  count of packets emitted.
- stat_trunc_count  out  32  count of truncated packets.

Behaviour:
- Reset: asynchronous on axis_resetn low. All outputs are 0, except s_axis_tready, which goes 1 on the first clock edge after reset release. The state machine is IDLE, the skid buffer is empty, and the counters are 0.
- Handshake and pipeline:
  - Beat transfers when valid and ready are both high.
  - Output register plus one skid register; latency is 1 cycle from s-accept to m_axis_tvalid.
  - Sustains 1 beat per cycle when m_axis_tready stays high.
  - s_axis_tready is registered and equals "skid empty".
  - m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- State machine:
  - IDLE: the next accepted beat is SOP. The output copy of that beat gets:
    - tuser[TS_LSB+31:TS_LSB] = sync_time_ptp_ns sampled in the accept cycle;
    - tuser[23:16] = SRC_PORT_ONEHOT;
    - tuser[64] = 0.
    All other tuser bits pass through.
    - byte_cnt = popcount(tkeep).
    - If tlast=1, stay in IDLE; otherwise go to IN_PKT.
  - IN_PKT: tuser passes through unmodified; byte_cnt += popcount(tkeep).
    - Accepted beat with tlast=1: go to IDLE.
  - Truncation (in IDLE or IN_PKT): if the updated byte_cnt > MAX_FRAME_BYTES and the beat's tlast=0:
    - the output beat has tlast forced to 1 and tuser[64]=1 (this also applies on the SOP beat);
    - go to DISCARD;
    - stat_trunc_count increments.
    If the updated count exceeds the limit but tlast=1, the beat passes unmodified, with no truncation.
  - DISCARD: accept beats (s_axis_tready follows normal rules) and emit nothing.
    - Accepted beat with tlast=1: go to IDLE.
- byte_cnt is 16 bits and saturates at 16'hFFFF.
- Beats with tkeep=0 are forwarded and add 0 bytes.
- The timestamp is a raw sample with no wrap correction; a packet at 999_999_992 stamps that value, and the next packet may stamp 0.
- Counters:
  - stat_pkt_count increments on each m-side beat transferred with m_axis_tlast=1.
  - Both counters wrap modulo 2^32.
  - stat_clear zeroes both counters. It takes priority over a same-cycle increment.
- Reset mid-packet: partial output is abandoned and the state returns to IDLE. The first beat accepted after reset is treated as SOP.

Optional Feature:
- RX_STAMPER_STATS_EN
  - Defined: the counters behave as specified above.
  - Undefined: no counter logic; stat_pkt_count and stat_trunc_count are tied to 0 and stat_clear is ignored.
  - The port list is identical in both builds.

Test Plan:
- 64-byte packet (2 beats, tkeep all-ones), sync_time_ptp_ns=1000 at SOP accept ->
  - beat0 tuser[63:32]=1000, tuser[23:16]=8'h01, tuser[64]=0;
  - beat1 tuser unchanged;
  - tlast on beat1;
  - stat_pkt_count=1.
- Back-to-back 1-beat packets, 100 beats, m_axis_tready=1 -> 100 output beats in 101 cycles, each stamped with a distinct timestamp that increases in steps of 8.
- m_axis_tready toggled 1010… during a 4-beat packet -> no beat lost or duplicated; data order preserved; s_axis_tready low at most 1 cycle in every 2.
- 1600-byte frame (50 beats of 32 bytes), MAX_FRAME_BYTES=1522 ->
  - 48 beats emitted;
  - beat 48 (1536 bytes) has tlast=1 and tuser[64]=1;
  - beats 49-50 dropped;
  - stat_trunc_count=1;
  - the following packet is stamped normally.
- SOP at sync_time_ptp_ns=999_999_992 and next SOP 1 cycle later -> stamps 999_999_992 and 0.
- axis_resetn pulsed low during beat 2 of a 4-beat packet -> all outputs 0 immediately; after release, the next beat is stamped as SOP and counters are 0.
